store_narrower: RTL

- Store-side counterpart of the load-path sign extender: accepts a 32-bit register value plus a size code and narrows it to byte, halfword or word.
- Emits the result as little-endian byte writes to a byte-wide data memory, one byte per memory handshake.
- Checks whether the value fits the target width, i.e. whether it equals the sign/zero extension of its own low bits, and flags overflow.
- Sits between the CPU store stage and the byte-addressed data RAM.

---
 rtl/store_narrower.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/store_narrower.sv
// store_narrower: narrows a 32-bit register value to byte/half/word and writes
// it little-endian to a byte-wide memory, one byte per mem_ack handshake.
// Flags narrowing overflow and illegal size / misaligned address on completion.
//
// state | meaning
// IDLE  | ready for a request; no memory activity
// WRITE | presenting byte r_idx, waiting for mem_ack
// FIN   | one-cycle done pulse carrying ovf/err
module store_narrower #(
    parameter int AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [AW-1:0] i_req_addr,
    input  logic [31:0]   i_req_data,
    input  logic [1:0]    i_req_size,
    input  logic          i_req_signed,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_wdata,
    input  logic          i_mem_ack,
    output logic          o_done,
    output logic          o_ovf,
    output logic          o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;
    logic [1:0]    r_idx;
    logic [1:0]    r_last;
    logic          r_ovf;
    logic          r_err;

    logic          w_accept;
    logic          w_err;
    logic          w_ovf_raw;
    logic          w_ovf;
    logic [1:0]    w_last;
    logic          w_ack_last;

    assign w_accept   = i_req_valid && (r_state == IDLE);
    assign w_ack_last = (r_state == WRITE) && i_mem_ack && (r_idx == r_last);
    // An erroring request never writes, so overflow is meaningless for it.
    assign w_ovf      = w_ovf_raw && !w_err;

    // Decode size into error, overflow and index of the final byte.
    always_comb begin
        w_err     = 1'b0;
        w_ovf_raw = 1'b0;
        w_last    = 2'd3;
        case (i_req_size)
            2'b00: begin
                w_last    = 2'd0;
                w_ovf_raw = i_req_signed ? !((&i_req_data[31:7]) || !(|i_req_data[31:7]))
                                         : (|i_req_data[31:8]);
            end
            2'b01: begin
                w_last    = 2'd1;
                w_err     = i_req_addr[0];
                w_ovf_raw = i_req_signed ? !((&i_req_data[31:15]) || !(|i_req_data[31:15]))
                                         : (|i_req_data[31:16]);
            end
            2'b10: begin
                w_last = 2'd3;
                w_err  = (i_req_addr[1:0] != 2'b00);
            end
            default: begin
                w_last = 2'd3;
                w_err  = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_err ? FIN : WRITE;
                end
            end
            WRITE: begin
                if (w_ack_last) begin
                    w_next = FIN;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Latch the request on acceptance and step the byte index on each ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_idx  <= 2'd0;
            r_last <= 2'd0;
            r_ovf  <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_addr <= i_req_addr;
            r_data <= i_req_data;
            r_idx  <= 2'd0;
            r_last <= w_last;
            r_ovf  <= w_ovf;
            r_err  <= w_err;
        end else if ((r_state == WRITE) && i_mem_ack && !w_ack_last) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Outputs are decoded from state so reset immediately silences the bus.
    always_comb begin
        o_req_ready = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = 8'h00;
        o_done      = 1'b0;
        o_ovf       = 1'b0;
        o_err       = 1'b0;
        case (r_state)
            IDLE: o_req_ready = 1'b1;
            WRITE: begin
                o_mem_we   = 1'b1;
                o_mem_addr = r_addr + {{(AW-2){1'b0}}, r_idx};
                case (r_idx)
                    2'd0:    o_mem_wdata = r_data[7:0];
                    2'd1:    o_mem_wdata = r_data[15:8];
                    2'd2:    o_mem_wdata = r_data[23:16];
                    default: o_mem_wdata = r_data[31:24];
                endcase
            end
            FIN: begin
                o_done = 1'b1;
                o_ovf  = r_ovf;
                o_err  = r_err;
            end
            default: ;
        endcase
    end

endmodule
